// File: rtl/jtcop_dial_nch_if.sv
// jtcop_dial_nch_if: per-channel dial inputs and CPU read port of jtcop_dial_nch
interface jtcop_dial_nch_if #(parameter int CH = 4);
  localparam int SW = CH > 1 ? $clog2(CH) : 1;
  logic LHBL;
  logic [CH-1:0] inc, dec, btn, ctr_rst, moved;
  logic cs, uln, cfn, sfn;
  logic [SW-1:0] sel;
  logic [7:0] dout;
  modport master(output LHBL, inc, dec, btn, ctr_rst, cs, sel, uln, input dout, cfn, sfn, moved);
  modport slave(input LHBL, inc, dec, btn, ctr_rst, cs, sel, uln, output dout, cfn, sfn, moved);
endinterface

// File: rtl/jtcop_dial_nch.sv
// jtcop_dial_nch: N-channel line-paced dial counters with snapshot-coherent byte reads
// Step acceleration is compiled in when JTCOP_DIAL_ACCEL_EN is defined.
module jtcop_dial_nch #(
  parameter int CH = 4,
  parameter int W = 12,
  parameter int HOLD = 8,
  parameter int STEP_MAX = 4
) (
  input logic clk,
  input logic rst,
  jtcop_dial_nch_if.slave bus
);
  logic lhbl_l, tick, cfn, sfn, ok;
  logic [7:0] dout;
  logic [W-1:0] snap, rd;
  logic [15:0] snap_x;
  logic [CH-1:0] moved;
  logic [CH*W-1:0] cnt_all;
  assign tick = ~bus.LHBL & lhbl_l;
  assign ok = 32'(bus.sel) < CH;
  assign rd = ok ? cnt_all[32'(bus.sel)*W +: W] : '0;
  assign snap_x = 16'($signed(snap));
`ifndef JTCOP_DIAL_ACCEL_EN
  logic unused_cfg;
  assign unused_cfg = ^{HOLD, STEP_MAX};
`endif
  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic up, dn, mv, mov;
    logic [3:0] step_eff;
    logic [W-1:0] cnt;
    assign up = bus.inc[i] & ~bus.dec[i];
    assign dn = bus.dec[i] & ~bus.inc[i];
    assign mv = tick & (up | dn);
`ifdef JTCOP_DIAL_ACCEL_EN
    logic [3:0] step, step_nx;
    logic [15:0] hold, hold_eff, hold_nx;
    logic last_up, rev, wrap;
    // a reversal restarts acceleration before the move is applied
    assign rev = up != last_up;
    assign step_eff = rev ? 4'd1 : step;
    assign hold_eff = rev ? '0 : hold;
    assign wrap = hold_eff == 16'(HOLD - 1);
    assign step_nx = ~mv ? 4'd1 : ~wrap ? step_eff :
                     step_eff >= 4'(STEP_MAX / 2) ? 4'(STEP_MAX) : step_eff << 1;
    assign hold_nx = ~mv | wrap ? '0 : hold_eff + 16'd1;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        step <= 4'd1;
        hold <= '0;
        last_up <= 1'b1;
      end else if (bus.ctr_rst[i]) begin
        step <= 4'd1;
        hold <= '0;
      end else if (tick) begin
        step <= step_nx;
        hold <= hold_nx;
        last_up <= mv ? up : last_up;
      end
`else
    assign step_eff = 4'd1;
`endif
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        cnt <= '0;
        mov <= 1'b0;
      end else if (bus.ctr_rst[i]) begin
        cnt <= '0;
        mov <= 1'b0;
      end else if (mv) begin
        cnt <= up ? cnt + W'(step_eff) : cnt - W'(step_eff);
        mov <= 1'b1;
      end
    assign cnt_all[i*W +: W] = cnt;
    assign moved[i] = mov;
  end
  // lower reads capture the whole counter so the upper byte matches it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lhbl_l <= 1'b1;
      dout <= 8'hFF;
      snap <= '0;
      cfn <= 1'b1;
      sfn <= 1'b1;
    end else begin
      lhbl_l <= bus.LHBL;
      cfn <= ~|bus.btn;
      sfn <= ~|moved;
      dout <= ~(bus.cs & ok) ? 8'hFF : bus.uln ? snap_x[15:8] : rd[7:0];
      if (bus.cs & ok & ~bus.uln) snap <= rd;
    end
  assign bus.dout = dout;
  assign bus.cfn = cfn;
  assign bus.sfn = sfn;
  assign bus.moved = moved;
endmodule

// File: tb/tb_jtcop_dial_nch.sv
// tb_jtcop_dial_nch: directed and random stimulus against a behavioural model of the dial counters
module tb_jtcop_dial_nch;
  localparam int CH = 5, W = 12, HOLD = 8, STEP_MAX = 4;
  localparam int SW = CH > 1 ? $clog2(CH) : 1;
  localparam int M = 1 << W;
`ifdef JTCOP_DIAL_ACCEL_EN
  localparam bit ACC = 1;
`else
  localparam bit ACC = 0;
`endif
  logic clk = 0, rst = 1;
  jtcop_dial_nch_if #(.CH(CH)) bus();
  jtcop_dial_nch #(.CH(CH), .W(W), .HOLD(HOLD), .STEP_MAX(STEP_MAX)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  int m_cnt[CH], m_step[CH], m_hold[CH], m_last[CH], m_moved[CH], rdir[CH];
  int m_snap, m_lhbl, m_dout, m_cfn, m_sfn;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] mv_exp();
    logic [31:0] r = '0;
    for (int i = 0; i < CH; i++) r[i] = m_moved[i] != 0;
    return r;
  endfunction
  task automatic m_reset();
    for (int i = 0; i < CH; i++) begin
      m_cnt[i] = 0; m_step[i] = 1; m_hold[i] = 0; m_last[i] = 1; m_moved[i] = 0;
    end
    m_snap = 0; m_lhbl = 1; m_dout = 255; m_cfn = 1; m_sfn = 1;
  endtask
  task automatic model_edge();
    bit tick;
    int s, v, dir;
    tick = !bus.LHBL && m_lhbl != 0;
    s = int'(bus.sel);
    m_lhbl = bus.LHBL;
    m_cfn = bus.btn == 0;
    m_sfn = 1;
    for (int i = 0; i < CH; i++) if (m_moved[i] != 0) m_sfn = 0;
    if (bus.cs && s < CH) begin
      if (!bus.uln) begin
        m_snap = m_cnt[s];
        m_dout = m_cnt[s] % 256;
      end else begin
        v = m_snap;
        if (v >= M / 2) v -= M;
        m_dout = (v >>> 8) & 255;
      end
    end else m_dout = 255;
    for (int i = 0; i < CH; i++) begin
      dir = (bus.inc[i] && !bus.dec[i]) ? 1 : (bus.dec[i] && !bus.inc[i]) ? -1 : 0;
      if (bus.ctr_rst[i]) begin
        m_cnt[i] = 0; m_step[i] = 1; m_hold[i] = 0; m_moved[i] = 0;
      end else if (tick) begin
        if (dir == 0) begin
          m_step[i] = 1; m_hold[i] = 0;
        end else begin
          if (ACC && dir != m_last[i]) begin m_step[i] = 1; m_hold[i] = 0; end
          m_cnt[i] = ((m_cnt[i] + dir * m_step[i]) % M + M) % M;
          m_moved[i] = 1;
          m_last[i] = dir;
          if (ACC) begin
            if (m_hold[i] == HOLD - 1) begin
              m_step[i] = m_step[i] * 2 > STEP_MAX ? STEP_MAX : m_step[i] * 2;
              m_hold[i] = 0;
            end else m_hold[i]++;
          end
        end
      end
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("dout", bus.dout, m_dout);
    check("cfn", bus.cfn, m_cfn);
    check("sfn", bus.sfn, m_sfn);
    check("moved", bus.moved, mv_exp());
  endtask
  task automatic line(input logic [CH-1:0] up, input logic [CH-1:0] dn);
    bus.inc = up; bus.dec = dn; bus.LHBL = 0;
    cyc();
    bus.LHBL = 1;
    cyc();
    bus.inc = '0; bus.dec = '0;
  endtask
  task automatic rd(input int s, input bit u);
    bus.cs = 1; bus.sel = SW'(s); bus.uln = u;
    cyc();
    bus.cs = 0;
  endtask
  initial begin
    bus.LHBL = 1; bus.inc = '0; bus.dec = '0; bus.btn = '0; bus.ctr_rst = '0;
    bus.cs = 0; bus.sel = '0; bus.uln = 0;
    for (int i = 0; i < CH; i++) rdir[i] = 0;
    m_reset();
    #12;
    check("rst_dout", bus.dout, 8'hFF);
    check("rst_cfn", bus.cfn, 1);
    check("rst_sfn", bus.sfn, 1);
    check("rst_moved", bus.moved, 0);
    rst = 0;
    repeat (3) line(5'b00001, 0);
    rd(0, 0); check("ch0_lo", bus.dout, 8'h03);
    rd(0, 1); check("ch0_hi", bus.dout, 8'h00);
    check("ch0_moved", bus.moved, 5'b00001);
    check("ch0_sfn", bus.sfn, 0);
    repeat (24) line(5'b00010, 0);
    rd(1, 0); check("ch1_accel", bus.dout, ACC ? 8'h38 : 8'h18);
    line(0, 0);
    line(5'b00010, 0);
    rd(1, 0); check("ch1_restart", bus.dout, ACC ? 8'h39 : 8'h19);
    line(0, 5'b00100);
    rd(2, 0); check("ch2_lo", bus.dout, 8'hFF);
    rd(2, 1); check("ch2_hi", bus.dout, 8'hFF);
    line(0, 5'b01000);
    line(5'b01000, 0);
    rd(3, 0); check("ch3_wrap_lo", bus.dout, 8'h00);
    rd(3, 1); check("ch3_wrap_hi", bus.dout, 8'h00);
    while (m_cnt[0] != 255) begin
      if (255 - m_cnt[0] >= 8) line(5'b00001, 0);
      else begin line(0, 0); line(5'b00001, 0); end
    end
    rd(0, 0); check("snap_lo", bus.dout, 8'hFF);
    line(0, 0);
    line(5'b00001, 0);
    rd(0, 1); check("snap_hi", bus.dout, 8'h00);
    rd(0, 0); check("live_lo", bus.dout, 8'h00);
    rd(0, 1); check("live_hi", bus.dout, 8'h01);
    bus.inc = 5'b00011; bus.ctr_rst = 5'b00010; bus.LHBL = 0;
    cyc();
    bus.ctr_rst = '0; bus.LHBL = 1;
    cyc();
    bus.inc = '0;
    rd(1, 0); check("clr_cnt", bus.dout, 8'h00);
    check("clr_moved", bus.moved[1], 0);
    line(5'b00010, 0);
    rd(1, 0); check("clr_step", bus.dout, 8'h01);
    bus.btn = 5'b00100;
    cyc();
    check("btn_cfn", bus.cfn, 0);
    bus.btn = '0;
    rd(5, 0); check("sel5", bus.dout, 8'hFF);
    rd(6, 1); check("sel6", bus.dout, 8'hFF);
    rd(7, 0); check("sel7", bus.dout, 8'hFF);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 99) == 0) rdir[i] = int'($urandom_range(0, 3));
        bus.inc[i] = rdir[i] == 1 || rdir[i] == 3;
        bus.dec[i] = rdir[i] == 2 || rdir[i] == 3;
        bus.ctr_rst[i] = $urandom_range(0, 99) == 0;
        bus.btn[i] = $urandom_range(0, 15) == 0;
      end
      bus.LHBL = $urandom_range(0, 2) != 0;
      bus.cs = $urandom_range(0, 1) == 1;
      bus.sel = SW'($urandom_range(0, (1 << SW) - 1));
      bus.uln = $urandom_range(0, 1) == 1;
      cyc();
      if (c == 1500) begin
        #2 rst = 1;
        #1;
        check("mid_rst_dout", bus.dout, 8'hFF);
        check("mid_rst_cfn", bus.cfn, 1);
        check("mid_rst_sfn", bus.sfn, 1);
        check("mid_rst_moved", bus.moved, 0);
        m_reset();
        bus.LHBL = 1;
        repeat (2) @(posedge clk);
        #2 rst = 0;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
